serial_subtractor: RTL

//  Bit-serial subtractor: computes D = A - B - BIN over WIDTH clock cycles, LSB first,

---
 rtl/serial_arith_pkg.sv | 34 +++
 rtl/full_subtractor_cell.sv | 26 ++
 rtl/serial_subtractor.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// ----------------------------------------------------------------------------
// serial_arith_pkg
// Shared definitions for the bit-serial arithmetic blocks:
//   - DEFAULT_WIDTH : default operand width
//   - STATE_W       : width of the controller state encoding
//   - state_t       : controller states (IDLE, SHIFT, FINISH)
//   - clog2()       : bit-count helper used to size the cycle counter
// ----------------------------------------------------------------------------
package serial_arith_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int STATE_W       = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Number of bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                res = i + 1;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// ----------------------------------------------------------------------------
// full_subtractor_cell
// Combinational one-bit full subtractor: diff = a - b - bin (mod 2), with the
// borrow-out raised when the subtraction of this bit needs to borrow.
// Ports:
//   a    in  minuend bit
//   b    in  subtrahend bit
//   bin  in  borrow-in
//   diff out difference bit
//   bout out borrow-out
// ----------------------------------------------------------------------------
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Difference and borrow equations of a single subtractor bit.
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor computing {bout, d} = a - b - bin over WIDTH cycles,
// LSB first, through a single full_subtractor_cell and a registered borrow.
// Optional build macro: SUB_OVF_FLAG_EN adds the signed-overflow output v.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   request, honoured only in IDLE or FINISH
//   a, b   in   WIDTH-bit minuend / subtrahend, captured on acceptance
//   bin    in   borrow-in, captured on acceptance
//   d      out  WIDTH-bit difference, updated only at completion
//   bout   out  final borrow-out
//   busy   out  high while shifting
//   done   out  one-cycle pulse when d/bout update
//   v      out  signed overflow (only with SUB_OVF_FLAG_EN)
// ----------------------------------------------------------------------------
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             busy,
    output logic             done
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             v
`endif
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_r;
    logic [WIDTH-1:0]   areg_r;
    logic [WIDTH-1:0]   breg_r;
    logic [WIDTH-1:0]   res_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   cnt_r;
`ifdef SUB_OVF_FLAG_EN
    logic               amsb_r;
    logic               bmsb_r;
`endif

    logic               cell_diff_s;
    logic               cell_bout_s;
    logic               accept_s;
    logic               last_s;
    logic [WIDTH-1:0]   final_res_s;

    full_subtractor_cell u_cell (
        .a    (areg_r[0]),
        .b    (breg_r[0]),
        .bin  (borrow_r),
        .diff (cell_diff_s),
        .bout (cell_bout_s)
    );

    // Acceptance, last-bit detection and the result as it will look after this shift.
    always_comb begin
        accept_s    = start & ((state_r == IDLE) | (state_r == FINISH));
        last_s      = (state_r == SHIFT) & (cnt_r == LAST_CNT);
        final_res_s = {cell_diff_s, res_r[WIDTH-1:1]};
    end

    // Controller, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            areg_r   <= '0;
            breg_r   <= '0;
            res_r    <= '0;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            d        <= '0;
            bout     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            amsb_r   <= 1'b0;
            bmsb_r   <= 1'b0;
            v        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE, FINISH: begin
                    done <= 1'b0;
                    if (accept_s) begin
                        areg_r   <= a;
                        breg_r   <= b;
                        res_r    <= '0;
                        borrow_r <= bin;
                        cnt_r    <= '0;
                        busy     <= 1'b1;
                        state_r  <= SHIFT;
`ifdef SUB_OVF_FLAG_EN
                        amsb_r   <= a[WIDTH-1];
                        bmsb_r   <= b[WIDTH-1];
`endif
                    end else begin
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    areg_r   <= {1'b0, areg_r[WIDTH-1:1]};
                    breg_r   <= {1'b0, breg_r[WIDTH-1:1]};
                    res_r    <= final_res_s;
                    borrow_r <= cell_bout_s;
                    cnt_r    <= cnt_r + CNT_ONE;
                    if (last_s) begin
                        // Outputs move only here, so they never show a partial result.
                        d       <= final_res_s;
                        bout    <= cell_bout_s;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= FINISH;
`ifdef SUB_OVF_FLAG_EN
                        // Operand signs differ and the result sign differs from the minuend.
                        v       <= (amsb_r ^ bmsb_r) & (amsb_r ^ cell_diff_s);
`endif
                    end else begin
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
